rst_seq: RTL and testbench
==========================

// Module: rst_seq
// PURPOSE
//   Reset sequencer directly downstream of clk_mgmt. It consumes the PLL output clock and the asynchronous LOCKED flag.
//   It produces ordered, glitch-free synchronous reset releases for the Ethernet/AXI core and its peripherals.
//   Resets release only after lock has been stable for a programmable time. Loss of lock re-asserts all resets and is counted.
//   A software soft-reset request is also supported.
// PARAMETERS
//   SYNC_STAGES         2    flops in the pll_locked synchronizer (>=2)
//   LOCK_STABLE_CYCLES  1024 consecutive synced-lock cycles required before core release (>=1)
//   PERIPH_DELAY_CYCLES 64   cycles between core release and peripheral release (>=1)
//   SOFT_RST_CYCLES     16   cycles both resets are held after a soft reset request (>=1)
//   CNT_WIDTH           8    width of lock_loss_cnt
// PORTS
//   clk_in          input  1          clock, driven by clk_mgmt clk_out
//   rst_in          input  1          async reset, active-high
//   pll_locked      input  1          clk_mgmt clk_locked; asynchronous to clk_in
//   soft_rst_req    input  1          sync single-cycle soft reset request
//   rst_core_out    output 1          core reset, active-high
//   rst_periph_out  output 1          peripheral reset, active-high
//   sys_ready       output 1          1 = sequence complete, system running
//   lock_loss_cnt   output CNT_WIDTH  saturating count of lock losses after core release
// BEHAVIOUR
//   Reset (rst_in=1, applied asynchronously):
//   - sync chain=0, state=WAIT_LOCK, counter=0
//   - rst_core_out=1, rst_periph_out=1, sys_ready=0, lock_loss_cnt=0
//   Release of rst_in is synchronous to clk_in.
//   Synchronizer: pll_locked goes through SYNC_STAGES flops to give locked_s. Only locked_s is used internally.
//   Counter width is $clog2 of the largest count parameter (+1). It is cleared on every state entry.
//   FSM (all transitions on clk_in rising edge):
//   - WAIT_LOCK: locked_s=1 -> DEBOUNCE.
//   - DEBOUNCE: locked_s=0 -> WAIT_LOCK, with no count increment. cnt==LOCK_STABLE_CYCLES-1 -> CORE_REL. Else cnt++.
//   - CORE_REL: cnt==PERIPH_DELAY_CYCLES-1 -> RUN. Else cnt++.
//   - RUN: soft_rst_req=1 -> SOFT.
//   - SOFT: cnt==SOFT_RST_CYCLES-1 -> CORE_REL, skipping debounce because lock is known good. Else cnt++.
//   - Any state except WAIT_LOCK/DEBOUNCE: locked_s=0 -> WAIT_LOCK.
//   Priority: lock loss > soft_rst_req > counter expiry.
//   - soft_rst_req outside RUN is ignored, not queued.
//   - soft_rst_req in the same cycle as lock loss: lock loss wins.
//   Outputs are registered from next-state and change one edge after the deciding edge, with no combinational paths:
//   - rst_core_out=1 in WAIT_LOCK, DEBOUNCE, SOFT; 0 in CORE_REL, RUN.
//   - rst_periph_out=0 only in RUN; sys_ready=1 only in RUN.
//   - rst_core_out=0 implies that rst_periph_out is released no earlier than rst_core_out.
//   Latency (edge 0 = first edge sampling pll_locked=1, lock held):
//   - rst_core_out falls after edge SYNC_STAGES+LOCK_STABLE_CYCLES.
//   - rst_periph_out falls and sys_ready rises PERIPH_DELAY_CYCLES edges later.
//   lock_loss_cnt:
//   - Increments by 1 on each transition to WAIT_LOCK caused by locked_s=0 from CORE_REL, RUN or SOFT.
//   - Saturates at all-ones (no wrap).
//   - Not incremented for dropouts during DEBOUNCE. Cleared only by rst_in.
//   Lock glitch shorter than one clk_in period: may or may not be captured. If captured, it is handled as a full loss.
//   rst_in asserted mid-sequence: immediate return to the reset values above, including lock_loss_cnt=0.
// TESTING (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, PERIPH_DELAY_CYCLES=4, SOFT_RST_CYCLES=3, CNT_WIDTH=2)
//   1 Power-up: rst_in pulse, then pll_locked=1 from edge 0 -> rst_core_out 0 after edge 10; rst_periph_out 0 and sys_ready 1 after edge 14.
//   2 Debounce: pll_locked drops for 3 cycles at edge 6 -> rst_core_out stays 1, lock_loss_cnt stays 0; full 8-cycle count restarts after relock.
//   3 Soft reset: single-cycle soft_rst_req in RUN -> both resets 1 and sys_ready 0 next edge. rst_core_out 0 three edges later; rst_periph_out 0 four edges after that.
//   4 Lock loss in RUN: pll_locked=0 -> resets assert and sys_ready falls 3 edges later; lock_loss_cnt=1. Four losses -> lock_loss_cnt saturates at 3.
//   5 Priority: soft_rst_req and lock loss in the same cycle -> FSM goes to WAIT_LOCK, lock_loss_cnt increments; soft_rst_req in DEBOUNCE is ignored.
//   6 Async reset: rst_in asserted mid-CORE_REL with clk_in stopped -> all outputs at reset values immediately, with no clock edge.

Source files
------------

// File: rtl/rst_seq.sv
// Reset sequencer placed after clk_mgmt. It synchronizes the PLL lock flag
// and waits for lock to stay stable before it releases the core reset. The
// peripheral reset is released a fixed number of cycles after the core reset.
// A loss of lock asserts both resets again and is counted. A software
// soft-reset request holds both resets for a short time and then runs the
// release sequence again.
module rst_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int PERIPH_DELAY_CYCLES = 64,
    parameter int SOFT_RST_CYCLES     = 16,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 pll_locked,
    input  logic                 soft_rst_req,
    output logic                 rst_core_out,
    output logic                 rst_periph_out,
    output logic                 sys_ready,
    output logic [CNT_WIDTH-1:0] lock_loss_cnt
);

    // The phase counter is wide enough for the longest of the three waits.
    localparam int MAX_AB    = (LOCK_STABLE_CYCLES > PERIPH_DELAY_CYCLES) ?
                               LOCK_STABLE_CYCLES : PERIPH_DELAY_CYCLES;
    localparam int MAX_COUNT = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT) + 1;

    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] PERIPH_LAST = CW'(PERIPH_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        DEBOUNCE,
        CORE_REL,
        RUN,
        SOFT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lock_lost;
    logic                   core_d, periph_d, ready_d;

    // Synchronizer chain that brings the asynchronous lock flag into the clk_in domain.
    // NOTE: sequential state uses non-blocking assignments, so every flop samples the
    // value from before the edge and the chain shifts by exactly one stage per clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state and phase-counter logic. Lock loss has priority over a soft
    // request, and a soft request has priority over counter expiry.
    // NOTE: every signal gets its default value first, so no path can leave a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lock_lost = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                // A dropout before the core is released is not a counted loss.
                if (!locked_s)               state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = CORE_REL;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            CORE_REL: begin
                if (!locked_s) begin
                    state_d   = WAIT_LOCK;
                    lock_lost = 1'b1;
                end else if (cnt_q == PERIPH_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d   = WAIT_LOCK;
                    lock_lost = 1'b1;
                end else if (soft_rst_req) begin
                    state_d = SOFT;
                end
            end
            SOFT: begin
                // Lock is known to be good here, so the debounce phase is skipped.
                if (!locked_s) begin
                    state_d   = WAIT_LOCK;
                    lock_lost = 1'b1;
                end else if (cnt_q == SOFT_LAST) begin
                    state_d = CORE_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // The output values are decoded from the next state, so the output flops
    // change on the same edge as the state flops.
    always_comb begin
        core_d   = !((state_d == CORE_REL) || (state_d == RUN));
        periph_d = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    // State, phase counter and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            rst_core_out   <= 1'b1;
            rst_periph_out <= 1'b1;
            sys_ready      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rst_core_out   <= core_d;
            rst_periph_out <= periph_d;
            sys_ready      <= ready_d;
        end
    end

    // Saturating lock-loss counter. Only rst_in clears it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Directed testbench for rst_seq with small parameter values. Each step pushes
// its expected outputs to a scoreboard queue. The step then drives the clock
// edges and pops the queue to compare against the DUT.
module tb_rst_seq;

    logic       clk_in = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_in;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       rst_core_out;
    logic       rst_periph_out;
    logic       sys_ready;
    logic [1:0] lock_loss_cnt;

    int n_asserts = 0;
    int n_fail    = 0;
    int edge_cnt  = 0;

    typedef struct {
        string      tag;
        logic       core;
        logic       periph;
        logic       ready;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .PERIPH_DELAY_CYCLES(4),
        .SOFT_RST_CYCLES    (3),
        .CNT_WIDTH          (2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pll_locked    (pll_locked),
        .soft_rst_req  (soft_rst_req),
        .rst_core_out  (rst_core_out),
        .rst_periph_out(rst_periph_out),
        .sys_ready     (sys_ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // The clock can be stopped while low to check the asynchronous reset path.
    always #5 if (clk_run) clk_in = ~clk_in;

    always @(posedge clk_in) edge_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, edges=%0d", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic core, input logic periph,
                            input logic ready, input logic [1:0] cnt);
        exp_t e;
        e.tag = tag; e.core = core; e.periph = periph; e.ready = ready; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Advance n rising edges. Outputs are sampled 1 time unit after the last edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_asserts++;
            assert (rst_core_out === e.core) else begin
                n_fail++;
                $error("FAIL %s rst_core_out got %b want %b", e.tag, rst_core_out, e.core);
            end
            n_asserts++;
            assert (rst_periph_out === e.periph) else begin
                n_fail++;
                $error("FAIL %s rst_periph_out got %b want %b", e.tag, rst_periph_out, e.periph);
            end
            n_asserts++;
            assert (sys_ready === e.ready) else begin
                n_fail++;
                $error("FAIL %s sys_ready got %b want %b", e.tag, sys_ready, e.ready);
            end
            n_asserts++;
            assert (lock_loss_cnt === e.cnt) else begin
                n_fail++;
                $error("FAIL %s lock_loss_cnt got %0d want %0d", e.tag, lock_loss_cnt, e.cnt);
            end
        end
    endtask

    initial begin
        int         snap;
        logic [1:0] exp_cnt;

        rst_in       = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;

        // Reset values while rst_in is held.
        push_exp("reset", 1, 1, 0, 0);
        #12;
        check();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        push_exp("idle", 1, 1, 0, 0);
        ticks(2);
        check();

        // Power-up. Lock is first sampled at edge 0. The core is released at edge 10 and the peripherals at edge 14.
        pll_locked = 1'b1;
        push_exp("pwr_e9", 1, 1, 0, 0);
        ticks(10);
        check();
        push_exp("pwr_e10", 0, 1, 0, 0);
        ticks(1);
        check();
        push_exp("pwr_e13", 0, 1, 0, 0);
        ticks(3);
        check();
        push_exp("pwr_e14", 0, 0, 1, 0);
        ticks(1);
        check();

        // Soft reset from RUN. SOFT holds for 3 edges and CORE_REL lasts 4 edges.
        soft_rst_req = 1'b1;
        push_exp("soft_enter", 1, 1, 0, 0);
        ticks(1);
        soft_rst_req = 1'b0;
        check();
        push_exp("soft_hold", 1, 1, 0, 0);
        ticks(2);
        check();
        push_exp("soft_core", 0, 1, 0, 0);
        ticks(1);
        check();
        push_exp("soft_pre_run", 0, 1, 0, 0);
        ticks(3);
        check();
        push_exp("soft_run", 0, 0, 1, 0);
        ticks(1);
        check();

        // Priority test. Lock loss and soft_rst_req are seen in the same cycle, and lock loss wins.
        pll_locked = 1'b0;
        push_exp("prio_pre", 0, 0, 1, 0);
        ticks(2);
        check();
        soft_rst_req = 1'b1;
        push_exp("prio_loss", 1, 1, 0, 1);
        ticks(1);
        soft_rst_req = 1'b0;
        check();
        // A soft_rst_req during DEBOUNCE is ignored. The release still happens at edge 10.
        pll_locked = 1'b1;
        ticks(6);
        soft_rst_req = 1'b1;
        push_exp("deb_soft_ign", 1, 1, 0, 1);
        ticks(1);
        soft_rst_req = 1'b0;
        check();
        push_exp("deb_e9", 1, 1, 0, 1);
        ticks(3);
        check();
        push_exp("deb_e10", 0, 1, 0, 1);
        ticks(1);
        check();
        push_exp("deb_run", 0, 0, 1, 1);
        ticks(4);
        check();

        // Repeated lock loss from RUN. The counter saturates at 3 and does not wrap.
        exp_cnt = 2'd1;
        for (int i = 0; i < 3; i++) begin
            pll_locked = 1'b0;
            push_exp("loss_pre", 0, 0, 1, exp_cnt);
            ticks(2);
            check();
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            push_exp("loss_hit", 1, 1, 0, exp_cnt);
            ticks(1);
            check();
            pll_locked = 1'b1;
            push_exp("loss_relock", 0, 0, 1, exp_cnt);
            ticks(15);
            check();
        end

        // Assert rst_in asynchronously during CORE_REL while the clock is stopped.
        soft_rst_req = 1'b1;
        ticks(1);
        soft_rst_req = 1'b0;
        push_exp("async_corerel", 0, 1, 0, 3);
        ticks(3);
        check();
        @(negedge clk_in);
        clk_run = 1'b0;
        #20;
        snap = edge_cnt;
        rst_in = 1'b1;
        push_exp("async_rst", 1, 1, 0, 0);
        #1;
        check();
        n_asserts++;
        assert (edge_cnt === snap) else begin
            n_fail++;
            $error("FAIL async_no_edge edges got %0d want %0d", edge_cnt, snap);
        end
        pll_locked = 1'b0;
        #20;
        clk_run = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        push_exp("async_after", 1, 1, 0, 0);
        ticks(1);
        check();

        // Debounce test. Lock drops at edge 6 for 3 cycles and must not count as a loss.
        // After relock at edge 9 the full count runs again, so the core is released at edge 19.
        pll_locked = 1'b1;
        ticks(6);
        pll_locked = 1'b0;
        push_exp("deb_drop", 1, 1, 0, 0);
        ticks(3);
        check();
        pll_locked = 1'b1;
        push_exp("deb_old_rel", 1, 1, 0, 0);
        ticks(2);
        check();
        push_exp("deb_e18", 1, 1, 0, 0);
        ticks(8);
        check();
        push_exp("deb_e19", 0, 1, 0, 0);
        ticks(1);
        check();
        push_exp("deb_e23", 0, 0, 1, 0);
        ticks(4);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
